// File: rtl/alarm_controller.sv
// Vehicle anti-theft controller: seven-state alarm FSM with a 1 Hz tick divider,
// seconds countdown timer, registered siren/LED outputs and an independent fuel-pump interlock.
module alarm_controller #(
    parameter int unsigned CLK_HZ      = 25000000,
    parameter int unsigned T_ARM       = 6,
    parameter int unsigned T_DRIVER    = 8,
    parameter int unsigned T_PASSENGER = 15,
    parameter int unsigned T_ALARM     = 10
) (
    input  logic       clock_25mhz,
    input  logic       reset,
    input  logic       ignition,
    input  logic       driver_door,
    input  logic       passenger_door,
    input  logic       hidden_switch,
    input  logic       brake_pedal,
    output logic       siren_enable,
    output logic       status_led,
    output logic       fuel_pump,
    output logic [2:0] state_out
);

    localparam int unsigned DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    typedef enum logic [2:0] {
        ARMED      = 3'd0,
        TRIGGERED  = 3'd1,
        SOUND      = 3'd2,
        DISARMED   = 3'd3,
        WAIT_OPEN  = 3'd4,
        WAIT_CLOSE = 3'd5,
        ARM_DELAY  = 3'd6
    } state_t;

    typedef enum logic {
        PUMP_OFF = 1'b0,
        PUMP_ON  = 1'b1
    } pump_t;

    state_t           state, next_state;
    pump_t            pump_state;
    logic [DIV_W-1:0] divider;
    logic [4:0]       timer;
    logic             tick, expire, any_door;
    logic             load;
    logic [4:0]       load_value;
    logic             next_siren, next_led;

    assign tick      = (divider == DIV_W'(CLK_HZ - 1));
    assign expire    = tick && (timer == 5'd1);
    assign any_door  = driver_door | passenger_door;
    assign state_out = state;
    assign fuel_pump = (pump_state == PUMP_ON);

    always_ff @(posedge clock_25mhz) begin
        if (reset) begin
            state <= ARMED;
        end else begin
            state <= next_state;
        end
    end

    // Timer loads are decided alongside the transitions since they share the same conditions.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        load_value = '0;
        case (state)
            ARMED: begin
                if (ignition) begin
                    next_state = DISARMED;
                end else if (driver_door) begin
                    next_state = TRIGGERED;
                    load       = 1'b1;
                    load_value = 5'(T_DRIVER);
                end else if (passenger_door) begin
                    next_state = TRIGGERED;
                    load       = 1'b1;
                    load_value = 5'(T_PASSENGER);
                end
            end
            TRIGGERED: begin
                if (ignition) begin
                    next_state = DISARMED;
                end else if (expire) begin
                    next_state = SOUND;
                    load       = 1'b1;
                    load_value = 5'(T_ALARM);
                end
            end
            SOUND: begin
                if (ignition) begin
                    next_state = DISARMED;
                end else if (any_door) begin
                    load       = 1'b1;
                    load_value = 5'(T_ALARM);
                end else if (expire) begin
                    next_state = ARMED;
                end
            end
            DISARMED: begin
                if (!ignition) begin
                    next_state = WAIT_OPEN;
                end
            end
            WAIT_OPEN: begin
                if (ignition) begin
                    next_state = DISARMED;
                end else if (driver_door) begin
                    next_state = WAIT_CLOSE;
                end
            end
            WAIT_CLOSE: begin
                if (ignition) begin
                    next_state = DISARMED;
                end else if (!driver_door) begin
                    next_state = ARM_DELAY;
                    load       = 1'b1;
                    load_value = 5'(T_ARM);
                end
            end
            ARM_DELAY: begin
                if (ignition) begin
                    next_state = DISARMED;
                end else if (any_door) begin
                    load       = 1'b1;
                    load_value = 5'(T_ARM);
                end else if (expire) begin
                    next_state = ARMED;
                end
            end
            default: next_state = ARMED;
        endcase
    end

    // LED blinks only while resting in ARMED; entering ARMED always starts dark.
    always_comb begin
        next_siren = (next_state == SOUND);
        next_led   = 1'b0;
        case (next_state)
            ARMED:            next_led = (state == ARMED) ? (status_led ^ tick) : 1'b0;
            TRIGGERED, SOUND: next_led = 1'b1;
            default:          next_led = 1'b0;
        endcase
    end

    always_ff @(posedge clock_25mhz) begin
        if (reset) begin
            divider      <= '0;
            timer        <= '0;
            siren_enable <= 1'b0;
            status_led   <= 1'b0;
        end else begin
            siren_enable <= next_siren;
            status_led   <= next_led;
            if (load) begin
                timer   <= load_value;
                divider <= '0;
            end else begin
                divider <= tick ? '0 : divider + 1'b1;
                if (tick && (timer != '0)) begin
                    timer <= timer - 5'd1;
                end
            end
        end
    end

    always_ff @(posedge clock_25mhz) begin
        if (reset) begin
            pump_state <= PUMP_OFF;
        end else begin
            case (pump_state)
                PUMP_OFF: if (ignition && hidden_switch && brake_pedal) pump_state <= PUMP_ON;
                PUMP_ON:  if (!ignition) pump_state <= PUMP_OFF;
                default:  pump_state <= PUMP_OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: elapsed-cycle reference model compared every
// cycle, plus directed scenarios with hand-computed edge-exact expectations.
module tb_alarm_controller;

    localparam int CLK = 10;
    localparam int TA  = 6;
    localparam int TD  = 8;
    localparam int TP  = 15;
    localparam int TAL = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ignition = 1'b0;
    logic       driver_door = 1'b0;
    logic       passenger_door = 1'b0;
    logic       hidden_switch = 1'b0;
    logic       brake_pedal = 1'b0;
    logic       siren_enable, status_led, fuel_pump;
    logic [2:0] state_out;

    int checks = 0;
    int errors = 0;

    alarm_controller #(
        .CLK_HZ(CLK), .T_ARM(TA), .T_DRIVER(TD), .T_PASSENGER(TP), .T_ALARM(TAL)
    ) dut (
        .clock_25mhz(clk),
        .reset(reset),
        .ignition(ignition),
        .driver_door(driver_door),
        .passenger_door(passenger_door),
        .hidden_switch(hidden_switch),
        .brake_pedal(brake_pedal),
        .siren_enable(siren_enable),
        .status_led(status_led),
        .fuel_pump(fuel_pump),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: timing expressed as cycles elapsed since the last countdown load.
    int m_state = 0, m_since = 0, m_dur = 0, ns, load_t;
    bit m_led = 0, m_siren = 0, m_pump = 0, m_valid = 0, ld, tk, ex, door;

    always @(posedge clk) begin
        if (reset) begin
            m_state = 0; m_since = 0; m_dur = 0;
            m_led = 0; m_siren = 0; m_pump = 0; m_valid = 1;
        end else if (m_valid) begin
            tk = (m_since % CLK) == CLK - 1;
            ex = (m_since + 1) == m_dur;
            door = driver_door || passenger_door;
            ns = m_state; ld = 0; load_t = 0;
            case (m_state)
                0: if (ignition) ns = 3;
                   else if (driver_door) begin ns = 1; ld = 1; load_t = TD; end
                   else if (passenger_door) begin ns = 1; ld = 1; load_t = TP; end
                1: if (ignition) ns = 3;
                   else if (ex) begin ns = 2; ld = 1; load_t = TAL; end
                2: if (ignition) ns = 3;
                   else if (door) begin ld = 1; load_t = TAL; end
                   else if (ex) ns = 0;
                3: if (!ignition) ns = 4;
                4: if (ignition) ns = 3; else if (driver_door) ns = 5;
                5: if (ignition) ns = 3;
                   else if (!driver_door) begin ns = 6; ld = 1; load_t = TA; end
                6: if (ignition) ns = 3;
                   else if (door) begin ld = 1; load_t = TA; end
                   else if (ex) ns = 0;
                default: ns = 0;
            endcase
            if (ns == 0) m_led = (m_state == 0) ? (m_led ^ tk) : 1'b0;
            else m_led = (ns == 1 || ns == 2);
            m_siren = (ns == 2);
            m_pump = m_pump ? ignition : (ignition && hidden_switch && brake_pedal);
            if (ld) begin m_since = 0; m_dur = load_t * CLK; end
            else m_since = m_since + 1;
            m_state = ns;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_state", int'(state_out), m_state);
            check("model_siren", int'(siren_enable), int'(m_siren));
            check("model_led", int'(status_led), int'(m_led));
            check("model_pump", int'(fuel_pump), int'(m_pump));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        pulse_reset();
        check("reset_state", int'(state_out), 0);
        check("reset_siren", int'(siren_enable), 0);
        check("reset_led", int'(status_led), 0);
        check("reset_pump", int'(fuel_pump), 0);
        step(9);  check("led_before_10", int'(status_led), 0);
        step(1);  check("led_at_10", int'(status_led), 1);
        step(9);  check("led_before_20", int'(status_led), 1);
        step(1);  check("led_at_20", int'(status_led), 0);
        step(30); check("led_at_50", int'(status_led), 1);
        check("idle_state", int'(state_out), 0);

        // Driver door pulse: entry delay 8 s, alarm 10 s after doors close.
        driver_door = 1'b1; step(1); driver_door = 1'b0;
        check("drv_trig_state", int'(state_out), 1);
        step(79); check("drv_siren_e79", int'(siren_enable), 0);
        step(1);  check("drv_siren_e80", int'(siren_enable), 1);
        check("drv_sound_state", int'(state_out), 2);
        step(99); check("drv_siren_e179", int'(siren_enable), 1);
        step(1);  check("drv_siren_e180", int'(siren_enable), 0);
        check("drv_rearmed", int'(state_out), 0);

        // Both doors together take the driver delay.
        driver_door = 1'b1; passenger_door = 1'b1; step(1);
        driver_door = 1'b0; passenger_door = 1'b0;
        step(79); check("both_siren_e79", int'(siren_enable), 0);
        step(1);  check("both_siren_e80", int'(siren_enable), 1);
        step(100); check("both_rearmed", int'(state_out), 0);

        // Passenger only: 15 s entry delay.
        passenger_door = 1'b1; step(1); passenger_door = 1'b0;
        step(79);  check("pas_siren_e80", int'(siren_enable), 0);
        step(70);  check("pas_siren_e149", int'(siren_enable), 0);
        step(1);   check("pas_siren_e150", int'(siren_enable), 1);

        // Door held open keeps SOUND going; reset wins.
        driver_door = 1'b1; step(150);
        check("held_sound", int'(state_out), 2);
        reset = 1'b1; step(1);
        check("rst_sound_state", int'(state_out), 0);
        check("rst_sound_siren", int'(siren_enable), 0);
        reset = 1'b0; driver_door = 1'b0;
        step(9);  check("rst_div_led9", int'(status_led), 0);
        step(1);  check("rst_div_led10", int'(status_led), 1);

        // Ignition during entry delay disarms.
        driver_door = 1'b1; step(1); driver_door = 1'b0;
        step(40); check("ign_pre_state", int'(state_out), 1);
        ignition = 1'b1; step(1);
        check("ign_disarmed", int'(state_out), 3);
        check("ign_no_siren", int'(siren_enable), 0);
        ignition = 1'b0; step(1); check("wait_open", int'(state_out), 4);
        driver_door = 1'b1; step(1); check("wait_close", int'(state_out), 5);
        step(3);
        driver_door = 1'b0; step(1); check("arm_delay", int'(state_out), 6);
        step(59); check("arm_f59", int'(state_out), 6);
        step(1);  check("arm_f60", int'(state_out), 0);

        // Arm delay restarted by a door reopening.
        ignition = 1'b1; step(1); check("ign2", int'(state_out), 3);
        ignition = 1'b0; step(1);
        driver_door = 1'b1; step(1);
        driver_door = 1'b0; step(1); check("arm_delay2", int'(state_out), 6);
        step(29); passenger_door = 1'b1; step(5); passenger_door = 1'b0;
        step(59); check("rearm_g59", int'(state_out), 6);
        step(1);  check("rearm_g60", int'(state_out), 0);

        // Fuel-pump interlock.
        ignition = 1'b1; brake_pedal = 1'b1; step(3);
        check("pump_brake_only", int'(fuel_pump), 0);
        hidden_switch = 1'b1; step(1); hidden_switch = 1'b0;
        check("pump_on", int'(fuel_pump), 1);
        brake_pedal = 1'b0; step(3);
        check("pump_latched", int'(fuel_pump), 1);
        ignition = 1'b0; step(1);
        check("pump_off", int'(fuel_pump), 0);
        check("pump_state_wait_open", int'(state_out), 4);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
Vehicle anti-theft controller that sits directly upstream of the siren tone generator and drives its enable input. It is a seven-state FSM that decides when to arm, trigger and sound, with a built-in 1 Hz tick divider and a seconds countdown timer. It also drives a status LED and a fuel-pump interlock. All inputs arrive already synchronized and debounced, and are level-sensitive, active-high.

Parameters:
CLK_HZ, 25000000, clock cycles per second tick; set to 10 in simulation.
T_ARM, 6, seconds from driver door closing until the system re-arms.
T_DRIVER, 8, seconds of entry delay after the driver door opens.
T_PASSENGER, 15, seconds of entry delay after a passenger door opens.
T_ALARM, 10, seconds the siren continues after all doors are closed.

Ports:
clock_25mhz  in  1  system clock
reset  in  1  synchronous, active-high reset
ignition  in  1  ignition switch on
driver_door  in  1  driver door open
passenger_door  in  1  passenger door open
hidden_switch  in  1  concealed fuel-pump enable switch
brake_pedal  in  1  brake pedal depressed
siren_enable  out  1  drives the siren's enable input
status_led  out  1  dashboard status LED
fuel_pump  out  1  fuel pump power
state_out  out  3  current state code, for debug display

Behaviour:
- One clock domain; all state is updated on the rising edge of clock_25mhz.
- reset has priority over every other input and takes effect at the next edge:
  - state = ARMED (code 0), timer = 0, divider = 0;
  - siren_enable = 0, status_led = 0, fuel_pump = 0.
- State codes: ARMED = 0, TRIGGERED = 1, SOUND = 2, DISARMED = 3, WAIT_OPEN = 4, WAIT_CLOSE = 5, ARM_DELAY = 6.
- Divider:
  - counts 0..CLK_HZ-1 and wraps;
  - tick is high for one cycle when divider = CLK_HZ-1;
  - every timer load clears the divider to 0, so the first second is always a full second.
- Timer:
  - the 5-bit value is loaded on the same edge that enters the state;
  - it decrements on each tick;
  - "expire" means tick while timer = 1, so the transition happens exactly T*CLK_HZ cycles after the loading edge.
- ARMED:
  - ignition = 1 -> DISARMED.
  - else driver_door = 1 -> TRIGGERED, load T_DRIVER.
  - else passenger_door = 1 -> TRIGGERED, load T_PASSENGER.
  - If both doors open on the same cycle, the driver delay is used.
  - status_led toggles on each tick (0.5 Hz blink) and is 0 on entry.
- TRIGGERED:
  - ignition = 1 -> DISARMED.
  - expire -> SOUND.
  - status_led = 1. Further door activity does not reload the timer.
- SOUND:
  - siren_enable = 1 and status_led = 1.
  - ignition = 1 -> DISARMED.
  - While any door is open, timer is held at T_ALARM and divider at 0.
  - With all doors closed, the countdown runs; expire -> ARMED.
  - A door reopening mid-countdown reloads T_ALARM.
- DISARMED:
  - siren_enable = 0 and status_led = 0.
  - ignition = 0 -> WAIT_OPEN.
- WAIT_OPEN:
  - ignition = 1 -> DISARMED.
  - driver_door = 1 -> WAIT_CLOSE.
- WAIT_CLOSE:
  - ignition = 1 -> DISARMED.
  - driver_door = 0 -> ARM_DELAY, load T_ARM.
- ARM_DELAY:
  - ignition = 1 -> DISARMED.
  - Any door open -> reload T_ARM and stay in ARM_DELAY.
  - expire -> ARMED.
- siren_enable is 1 only in SOUND and is registered, so it changes on the transition edge.
- Fuel pump: a separate 2-state register, independent of the alarm FSM.
  - OFF -> ON when ignition, hidden_switch and brake_pedal are all 1 on the same cycle.
  - ON -> OFF when ignition = 0.
  - hidden_switch and brake_pedal are ignored while ON.
- state_out reflects the registered state code.

Test Plan:
(All scenarios use CLK_HZ = 10 and default T values.)
- Reset, then idle 50 cycles -> state_out = 0, siren_enable = 0, status_led toggles every 10 cycles starting at cycle 10, fuel_pump = 0.
- From ARMED, driver_door = 1 for one cycle at edge E -> state_out = 1 from E; siren_enable rises exactly at E+80; with doors closed it falls at E+80+100 and state returns to 0.
- From ARMED, passenger_door and driver_door both 1 at E -> siren rises at E+80, not E+150. Repeat with passenger_door only -> siren rises at E+150.
- In TRIGGERED, assert ignition at E+40 -> state = 3 at E+41, siren never asserts. Then: ignition off, driver door open, driver door close at F -> ARMED at F+60. Reopen a door at F+30 and close it at G -> ARMED at G+60.
- Fuel pump:
  - ignition = 1 with brake_pedal only -> fuel_pump stays 0.
  - Add hidden_switch for one cycle -> fuel_pump = 1 next edge and stays 1 after both drop.
  - ignition = 0 -> fuel_pump = 0 next edge.
- Assert reset during SOUND with door held open -> next edge: state 0, siren_enable 0, timer and divider 0.
